irq_ctrl: RTL and testbench

Interrupt controller that drives the interrupt side of the core's PC/utility unit: `irr`, `irr_dest` and `irr_ret`. It latches external interrupt requests, applies a software mask, and selects one request by fixed priority. It redirects the PC to a per-line vector at an instruction boundary and holds the saved return PC until the handler executes RETIRQ. It sits beside the utility unit and shares `clk`, `rst`, `enable_int`, `opcode` and `pc` with it.

---
 rtl/irq_ctrl_if.sv | 27 ++
 rtl/irq_ctrl.sv | 124 ++++++++++++
 tb/tb_irq_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// Bundles the commit-side inputs, request/mask inputs and redirect outputs of irq_ctrl.
// The master modport drives the inputs; the slave modport belongs to the controller.
interface irq_ctrl_if #(
  parameter int unsigned N_IRQ = 8
);
  logic             enable_int;
  logic [31:0]      pc;
  logic [11:0]      opcode;
  logic [N_IRQ-1:0] irq_lines;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_wdata;
  logic             irr;
  logic [31:0]      irr_dest;
  logic [31:0]      irr_ret;
  logic [N_IRQ-1:0] irq_ack;
  logic             in_service;

  modport master (
    output enable_int, pc, opcode, irq_lines, mask_we, mask_wdata,
    input  irr, irr_dest, irr_ret, irq_ack, in_service
  );

  modport slave (
    input  enable_int, pc, opcode, irq_lines, mask_we, mask_wdata,
    output irr, irr_dest, irr_ret, irq_ack, in_service
  );
endinterface

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller that redirects the PC at an instruction boundary.
// Define IRQ_EDGE_EN for rising-edge requests; the default build is level-triggered.
module irq_ctrl #(
  parameter int unsigned N_IRQ      = 8,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int unsigned VEC_STRIDE = 16
) (
  input logic       clk,
  input logic       rst,
  irq_ctrl_if.slave bus
);
  localparam int unsigned SEL_W     = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam logic [11:0] OP_RETIRQ = 12'b001110011000;

  typedef enum logic [1:0] {IDLE, TAKE, SERVICE} state_t;

  state_t           state;
  state_t           state_next;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] cand;
  logic [N_IRQ-1:0] sel_onehot;
  logic [N_IRQ-1:0] irq_ack_q;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] win_idx;
  logic [31:0]      irr_ret_q;
  logic             load_sel;
  logic             take_commit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
    end else if (bus.mask_we) begin
      mask <= bus.mask_wdata;
    end
  end

  assign sel_onehot = N_IRQ'(1) << sel;

`ifdef IRQ_EDGE_EN
  logic [N_IRQ-1:0] prev;

  // A new rising edge on the line being acknowledged wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= '0;
      pending <= '0;
    end else begin
      prev    <= bus.irq_lines;
      pending <= (pending & ~(take_commit ? sel_onehot : '0)) | (bus.irq_lines & ~prev);
    end
  end
`else
  assign pending = bus.irq_lines;
`endif

  assign cand = pending & mask;

  always_comb begin
    win_idx = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_idx = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // TAKE is committed once entered: only enable_int moves it on.
  always_comb begin
    state_next  = state;
    load_sel    = 1'b0;
    take_commit = 1'b0;
    case (state)
      IDLE: begin
        if (|cand) begin
          load_sel   = 1'b1;
          state_next = TAKE;
        end
      end
      TAKE: begin
        if (bus.enable_int) begin
          take_commit = 1'b1;
          state_next  = SERVICE;
        end
      end
      SERVICE: begin
        if (bus.enable_int && (bus.opcode == OP_RETIRQ)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel       <= '0;
      irr_ret_q <= '0;
      irq_ack_q <= '0;
    end else begin
      irq_ack_q <= take_commit ? sel_onehot : '0;
      if (load_sel) begin
        sel <= win_idx;
      end
      if (take_commit) begin
        irr_ret_q <= bus.pc;
      end
    end
  end

  assign bus.irr        = (state == TAKE);
  assign bus.irr_dest   = (state == TAKE) ? (VEC_BASE + (32'(sel) * VEC_STRIDE)) : 32'h0;
  assign bus.irr_ret    = irr_ret_q;
  assign bus.irq_ack    = irq_ack_q;
  assign bus.in_service = (state == SERVICE);
endmodule

// File: tb/tb_irq_ctrl.sv
// Table-driven scoreboard bench for irq_ctrl; follows IRQ_EDGE_EN to pick the matching vectors.
module tb_irq_ctrl;
  localparam logic [11:0] RET = 12'b001110011000;
  localparam logic [11:0] NOP = 12'h000;

  typedef struct {
    string       name;
    logic [7:0]  lines;
    logic        we;
    logic [7:0]  wdata;
    logic        en;
    logic [31:0] pc;
    logic [11:0] op;
    logic        irr;
    logic [31:0] dest;
    logic [31:0] ret;
    logic [7:0]  ack;
    logic        ins;
  } vec_t;

  typedef struct {
    string       name;
    logic        irr;
    logic [31:0] dest;
    logic [31:0] ret;
    logic [7:0]  ack;
    logic        ins;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   failures  = 0;
  vec_t vecs[$];
  exp_t exp_q[$];

  irq_ctrl_if #(.N_IRQ(8)) bus ();

  irq_ctrl #(
    .N_IRQ(8),
    .VEC_BASE(32'h0000_0100),
    .VEC_STRIDE(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic addVec(input string name, input logic [7:0] lines, input logic we,
                        input logic [7:0] wdata, input logic en, input logic [31:0] pc,
                        input logic [11:0] op, input logic irr, input logic [31:0] dest,
                        input logic [31:0] ret, input logic [7:0] ack, input logic ins);
    vec_t v;
    v.name = name; v.lines = lines; v.we = we; v.wdata = wdata; v.en = en; v.pc = pc;
    v.op = op; v.irr = irr; v.dest = dest; v.ret = ret; v.ack = ack; v.ins = ins;
    vecs.push_back(v);
  endtask

  task automatic compareNow(input string name, input logic irr, input logic [31:0] dest,
                            input logic [31:0] ret, input logic [7:0] ack, input logic ins);
    tests_run++;
    if ({bus.irr, bus.irr_dest, bus.irr_ret, bus.irq_ack, bus.in_service} !==
        {irr, dest, ret, ack, ins}) begin
      failures++;
      $display("[TB] FAIL %s: got irr=%0b dest=%h ret=%h ack=%h ins=%0b, expected irr=%0b dest=%h ret=%h ack=%h ins=%0b",
               name, bus.irr, bus.irr_dest, bus.irr_ret, bus.irq_ack, bus.in_service,
               irr, dest, ret, ack, ins);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    bus.irq_lines  = v.lines;
    bus.mask_we    = v.we;
    bus.mask_wdata = v.wdata;
    bus.enable_int = v.en;
    bus.pc         = v.pc;
    bus.opcode     = v.op;
    e.name = v.name; e.irr = v.irr; e.dest = v.dest; e.ret = v.ret; e.ack = v.ack; e.ins = v.ins;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      tests_run++;
      failures++;
      $display("[TB] FAIL scoreboard: got empty queue, expected a pending entry");
    end else begin
      e = exp_q.pop_front();
      compareNow(e.name, e.irr, e.dest, e.ret, e.ack, e.ins);
    end
  endtask

  task automatic runVecs();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput();
    end
    vecs.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ret_prev;
    bus.irq_lines  = 8'h00;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = 8'h00;
    bus.enable_int = 1'b0;
    bus.pc         = 32'h0;
    bus.opcode     = NOP;
    repeat (2) @(posedge clk);
    #1;
    compareNow("reset_values", 1'b0, 32'h0, 32'h0, 8'h00, 1'b0);
    rst = 1'b0;

`ifdef IRQ_EDGE_EN
    addVec("mask_ff",        8'h00, 1, 8'hFF, 0, 32'h0,  NOP, 0, 32'h0,   32'h0,  8'h00, 0);
    addVec("pulse3",         8'h08, 0, 8'h00, 0, 32'h0,  NOP, 0, 32'h0,   32'h0,  8'h00, 0);
    addVec("take3",          8'h00, 0, 8'h00, 0, 32'h0,  NOP, 1, 32'h130, 32'h0,  8'h00, 0);
    addVec("ack3",           8'h00, 0, 8'h00, 1, 32'h40, NOP, 0, 32'h0,   32'h40, 8'h08, 1);
    addVec("svc_pulse1",     8'h02, 0, 8'h00, 0, 32'h0,  NOP, 0, 32'h0,   32'h40, 8'h00, 1);
    addVec("svc_nonest",     8'h00, 0, 8'h00, 0, 32'h0,  NOP, 0, 32'h0,   32'h40, 8'h00, 1);
    addVec("retirq3",        8'h00, 0, 8'h00, 1, 32'h0,  RET, 0, 32'h0,   32'h40, 8'h00, 0);
    addVec("take1_after",    8'h00, 0, 8'h00, 0, 32'h0,  NOP, 1, 32'h110, 32'h40, 8'h00, 0);
    addVec("ack1",           8'h00, 0, 8'h00, 1, 32'h44, NOP, 0, 32'h0,   32'h44, 8'h02, 1);
    addVec("retirq1",        8'h00, 0, 8'h00, 1, 32'h0,  RET, 0, 32'h0,   32'h44, 8'h00, 0);
    addVec("mask_fe",        8'h00, 1, 8'hFE, 0, 32'h0,  NOP, 0, 32'h0,   32'h44, 8'h00, 0);
    addVec("pulse0_masked",  8'h01, 0, 8'h00, 0, 32'h0,  NOP, 0, 32'h0,   32'h44, 8'h00, 0);
    addVec("line0_masked",   8'h00, 0, 8'h00, 0, 32'h0,  NOP, 0, 32'h0,   32'h44, 8'h00, 0);
    addVec("unmask0",        8'h00, 1, 8'hFF, 0, 32'h0,  NOP, 0, 32'h0,   32'h44, 8'h00, 0);
    addVec("take0_retained", 8'h00, 0, 8'h00, 0, 32'h0,  NOP, 1, 32'h100, 32'h44, 8'h00, 0);
    addVec("ack0",           8'h00, 0, 8'h00, 1, 32'h48, NOP, 0, 32'h0,   32'h48, 8'h01, 1);
    addVec("retirq0",        8'h00, 0, 8'h00, 1, 32'h0,  RET, 0, 32'h0,   32'h48, 8'h00, 0);
    addVec("pulse5_2",       8'h24, 0, 8'h00, 0, 32'h0,  NOP, 0, 32'h0,   32'h48, 8'h00, 0);
    addVec("prio2",          8'h24, 0, 8'h00, 0, 32'h0,  NOP, 1, 32'h120, 32'h48, 8'h00, 0);
    addVec("ack2",           8'h24, 0, 8'h00, 1, 32'h50, NOP, 0, 32'h0,   32'h50, 8'h04, 1);
    addVec("retirq2",        8'h00, 0, 8'h00, 1, 32'h0,  RET, 0, 32'h0,   32'h50, 8'h00, 0);
    addVec("take5",          8'h00, 0, 8'h00, 0, 32'h0,  NOP, 1, 32'h150, 32'h50, 8'h00, 0);
    addVec("ack5",           8'h00, 0, 8'h00, 1, 32'h54, NOP, 0, 32'h0,   32'h54, 8'h20, 1);
    addVec("retirq5",        8'h00, 0, 8'h00, 1, 32'h0,  RET, 0, 32'h0,   32'h54, 8'h00, 0);
    addVec("pulse3_again",   8'h08, 0, 8'h00, 0, 32'h0,  NOP, 0, 32'h0,   32'h54, 8'h00, 0);
    addVec("take3_again",    8'h00, 0, 8'h00, 0, 32'h0,  NOP, 1, 32'h130, 32'h54, 8'h00, 0);
    addVec("ack3_reassert",  8'h08, 0, 8'h00, 1, 32'h60, NOP, 0, 32'h0,   32'h60, 8'h08, 1);
    addVec("retirq_set_won", 8'h00, 0, 8'h00, 1, 32'h0,  RET, 0, 32'h0,   32'h60, 8'h00, 0);
    addVec("take3_set_won",  8'h00, 0, 8'h00, 0, 32'h0,  NOP, 1, 32'h130, 32'h60, 8'h00, 0);
    addVec("ack3_set_won",   8'h00, 0, 8'h00, 1, 32'h64, NOP, 0, 32'h0,   32'h64, 8'h08, 1);
    addVec("retirq_last",    8'h00, 0, 8'h00, 1, 32'h0,  RET, 0, 32'h0,   32'h64, 8'h00, 0);
    addVec("retirq_outside", 8'h00, 0, 8'h00, 1, 32'h0,  RET, 0, 32'h0,   32'h64, 8'h00, 0);
    ret_prev = 32'h64;
`else
    addVec("idle_masked",    8'h10, 0, 8'h00, 0, 32'h0,   NOP, 0, 32'h0,   32'h0,   8'h00, 0);
    addVec("mask_ff",        8'h10, 1, 8'hFF, 0, 32'h0,   NOP, 0, 32'h0,   32'h0,   8'h00, 0);
    addVec("take4",          8'h10, 0, 8'h00, 0, 32'h0,   NOP, 1, 32'h140, 32'h0,   8'h00, 0);
    for (int i = 0; i < 4; i++)
      addVec("hold4",        8'h10, 0, 8'h00, 0, 32'h0,   NOP, 1, 32'h140, 32'h0,   8'h00, 0);
    addVec("ack4",           8'h10, 0, 8'h00, 1, 32'h40,  NOP, 0, 32'h0,   32'h40,  8'h10, 1);
    addVec("svc_nonest",     8'h12, 0, 8'h00, 0, 32'h0,   NOP, 0, 32'h0,   32'h40,  8'h00, 1);
    addVec("svc_other_op",   8'h12, 0, 8'h00, 1, 32'h0,   NOP, 0, 32'h0,   32'h40,  8'h00, 1);
    addVec("retirq4",        8'h02, 0, 8'h00, 1, 32'h0,   RET, 0, 32'h0,   32'h40,  8'h00, 0);
    addVec("take1",          8'h02, 0, 8'h00, 0, 32'h0,   NOP, 1, 32'h110, 32'h40,  8'h00, 0);
    addVec("take_committed", 8'h00, 1, 8'h00, 0, 32'h0,   NOP, 1, 32'h110, 32'h40,  8'h00, 0);
    addVec("ack1",           8'h00, 0, 8'h00, 1, 32'h200, NOP, 0, 32'h0,   32'h200, 8'h02, 1);
    addVec("retirq1",        8'h00, 0, 8'h00, 1, 32'h0,   RET, 0, 32'h0,   32'h200, 8'h00, 0);
    addVec("masked_off",     8'h01, 0, 8'h00, 0, 32'h0,   NOP, 0, 32'h0,   32'h200, 8'h00, 0);
    addVec("mask_fe",        8'h01, 1, 8'hFE, 0, 32'h0,   NOP, 0, 32'h0,   32'h200, 8'h00, 0);
    addVec("line0_masked",   8'h01, 0, 8'h00, 0, 32'h0,   NOP, 0, 32'h0,   32'h200, 8'h00, 0);
    addVec("prio2",          8'h24, 0, 8'h00, 0, 32'h0,   NOP, 1, 32'h120, 32'h200, 8'h00, 0);
    addVec("ack2",           8'h24, 0, 8'h00, 1, 32'h80,  NOP, 0, 32'h0,   32'h80,  8'h04, 1);
    addVec("retirq2",        8'h20, 0, 8'h00, 1, 32'h0,   RET, 0, 32'h0,   32'h80,  8'h00, 0);
    addVec("take5",          8'h20, 0, 8'h00, 0, 32'h0,   NOP, 1, 32'h150, 32'h80,  8'h00, 0);
    addVec("ack5",           8'h20, 0, 8'h00, 1, 32'h84,  NOP, 0, 32'h0,   32'h84,  8'h20, 1);
    addVec("retirq5",        8'h00, 0, 8'h00, 1, 32'h0,   RET, 0, 32'h0,   32'h84,  8'h00, 0);
    addVec("retirq_outside", 8'h00, 0, 8'h00, 1, 32'h0,   RET, 0, 32'h0,   32'h84,  8'h00, 0);
    ret_prev = 32'h84;
`endif
    runVecs();

    // Reset while TAKE is holding irr must drop it without waiting for a clock edge.
`ifdef IRQ_EDGE_EN
    addVec("pre_rst_pend3",  8'h08, 0, 8'h00, 0, 32'h0, NOP, 0, 32'h0,   ret_prev, 8'h00, 0);
`endif
    addVec("pre_rst_take3",  8'h08, 0, 8'h00, 0, 32'h0, NOP, 1, 32'h130, ret_prev, 8'h00, 0);
    runVecs();
    #3;
    rst = 1'b1;
    #1;
    compareNow("async_rst", 1'b0, 32'h0, 32'h0, 8'h00, 1'b0);
    bus.irq_lines = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    addVec("post_rst_mask",  8'h00, 1, 8'hFF, 0, 32'h0, NOP, 0, 32'h0, 32'h0, 8'h00, 0);
    addVec("post_rst_idle1", 8'h00, 0, 8'h00, 0, 32'h0, NOP, 0, 32'h0, 32'h0, 8'h00, 0);
    addVec("post_rst_idle2", 8'h00, 0, 8'h00, 0, 32'h0, NOP, 0, 32'h0, 32'h0, 8'h00, 0);
    runVecs();

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule
